alu_share_arbiter: RTL and testbench

//  Shares one 32-bit ALU instance among NUM_REQ requesters using per-requester valid/ready handshakes.

---
 rtl/alu_arb_pkg.sv | 40 ++++
 rtl/alu32.sv | 29 ++
 rtl/rr_pick_arbiter.sv | 23 ++
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU control codes,
// response FSM states and the round-robin pick function.
package alu_arb_pkg;

    localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOR  = 4'b1100;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_e;

    // First set bit scanning ptr, ptr+1, ... modulo n (n <= 8, ptr < n).
    function automatic logic [2:0] rr_pick(
        input logic [7:0]  valid,
        input logic [2:0]  ptr,
        input int unsigned n
    );
        logic [2:0]  idx;
        logic        found;
        int unsigned j;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            j = 32'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && !found && valid[j[2:0]]) begin
                idx   = j[2:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu32.sv
// 32-bit ALU shared by all requesters of alu_share_arbiter.
// Unlisted control encodings produce zero.
module alu32
    import alu_arb_pkg::*;
(
    input  logic [3:0]  ctrl_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_CTRL_AND:  result_o = a_i & b_i;
            ALU_CTRL_OR:   result_o = a_i | b_i;
            ALU_CTRL_ADD:  result_o = a_i + b_i;
            ALU_CTRL_SUB:  result_o = a_i - b_i;
            ALU_CTRL_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_CTRL_NOR:  result_o = ~(a_i | b_i);
            ALU_CTRL_SLTU: result_o = {31'b0, a_i < b_i};
            default:       result_o = '0;
        endcase
    end

    assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/rr_pick_arbiter.sv
// Combinational round-robin picker: one-hot grant plus encoded index.
// Purely combinational; the pointer lives in the parent.
module rr_pick_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [2:0] pick;

    assign pick  = rr_pick(8'(valid_i), 3'(ptr_i), NUM_REQ);
    assign idx_o = ID_W'(pick);
    assign any_o = |valid_i;
    assign gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters with a one-entry
// registered response. Define ALU_ARB_LOCK_EN to enable grant locking.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_src1_i,
    input  logic [NUM_REQ*32-1:0] req_src2_i,
    input  logic [NUM_REQ*4-1:0]  req_ctrl_i,
    input  logic [NUM_REQ-1:0]    req_lock_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [31:0]           rsp_result_o,
    output logic                  rsp_zero_o
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, ptr_next;
    logic [ID_W-1:0]     arb_ptr, g_idx;
    logic [NUM_REQ-1:0]  arb_valid, gnt;
    logic                any, in_rdy, fire;
    logic [31:0]         alu_a, alu_b, alu_res;
    logic [3:0]          alu_ctrl;
    logic                alu_zero;
    logic [ID_W-1:0]     id_q;
    logic [31:0]         res_q;
    logic                zero_q;

`ifdef ALU_ARB_LOCK_EN
    logic                lock_q, lock_d;
    logic [ID_W-1:0]     owner_q, owner_d;

    // While locked only the owner is visible to the picker.
    assign arb_valid = lock_q ? (req_valid_i & (NUM_REQ'(1) << owner_q))
                              : req_valid_i;
    assign arb_ptr   = lock_q ? owner_q : ptr_q;
`else
    logic                unused_lock;

    assign unused_lock = ^req_lock_i;
    assign arb_valid   = req_valid_i;
    assign arb_ptr     = ptr_q;
`endif

    rr_pick_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid_i (arb_valid),
        .ptr_i   (arb_ptr),
        .gnt_o   (gnt),
        .idx_o   (g_idx),
        .any_o   (any)
    );

    assign in_rdy      = (state_q == IDLE) | rsp_ready_i;
    assign req_ready_o = gnt & {NUM_REQ{in_rdy & rst_i}};
    assign fire        = any & in_rdy & rst_i;
    assign ptr_next    = (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

    assign alu_a    = req_src1_i[int'(g_idx)*32 +: 32];
    assign alu_b    = req_src2_i[int'(g_idx)*32 +: 32];
    assign alu_ctrl = req_ctrl_i[int'(g_idx)*4 +: 4];

    alu32 u_alu (
        .ctrl_i   (alu_ctrl),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
`ifdef ALU_ARB_LOCK_EN
        lock_d  = lock_q;
        owner_d = owner_q;
`endif
        if (fire) begin
            state_d = FULL;
            ptr_d   = ptr_next;
`ifdef ALU_ARB_LOCK_EN
            lock_d  = req_lock_i[g_idx];
            owner_d = g_idx;
`endif
        end else if (state_q == FULL && rsp_ready_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_q  <= 1'b0;
            owner_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef ALU_ARB_LOCK_EN
            lock_q  <= lock_d;
            owner_q <= owner_d;
`endif
            if (fire) begin
                id_q   <= g_idx;
                res_q  <= alu_res;
                zero_q <= alu_zero;
            end
        end
    end

    assign rsp_valid_o  = (state_q == FULL);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = res_q;
    assign rsp_zero_o   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table plus multi-cycle
// sequences for arbitration, backpressure, async reset and locking.
module tb_alu_share_arbiter;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] src1, src2;
    logic [N*4-1:0]  ctrl;
    logic [N-1:0]  lock;
    logic          rsp_valid, rsp_ready, rsp_zero;
    logic          rsp_id;
    logic [31:0]   rsp_result;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_src1_i   (src1),
        .req_src2_i   (src2),
        .req_ctrl_i   (ctrl),
        .req_lock_i   (lock),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero)
    );

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic set_op(input int k, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        src1[k*32 +: 32] = a;
        src2[k*32 +: 32] = b;
        ctrl[k*4 +: 4]   = op;
    endtask

    initial begin
        vt[0] = '{0, 4'b0010, 32'd5,        32'd7,        32'd12,       1'b0};
        vt[1] = '{1, 4'b0110, 32'd3,        32'd3,        32'd0,        1'b1};
        vt[2] = '{0, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vt[3] = '{1, 4'b1111, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vt[4] = '{0, 4'b1111, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
        vt[5] = '{1, 4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        vt[6] = '{0, 4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0};
        vt[7] = '{1, 4'b1100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0};
        vt[8] = '{0, 4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
        vt[9] = '{1, 4'b0111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};

        rst_n = 1'b0;
        req_valid = '0;
        src1 = '0;
        src2 = '0;
        ctrl = '0;
        lock = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_zero", 32'(rsp_zero), 32'd0);
        req_valid = 2'b01;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one requester at a time, 1-cycle latency.
        for (int i = 0; i < 10; i++) begin
            set_op(vt[i].id, vt[i].op, vt[i].a, vt[i].b);
            req_valid = N'(1) << vt[i].id;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready),
                32'(N'(1) << vt[i].id));
            @(posedge clk);
            #1;
            req_valid = '0;
            chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(vt[i].id));
            chk($sformatf("v%0d_res", i), rsp_result, vt[i].res);
            chk($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vt[i].z));
        end
        @(posedge clk);
        #1;
        chk("drain_idle", 32'(rsp_valid), 32'd0);

        // Alternating grants from a fresh pointer.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        set_op(0, 4'b0110, 32'd3, 32'd3);
        set_op(1, 4'b0111, 32'hFFFFFFFF, 32'd1);
        req_valid = 2'b11;
        #1;
        chk("alt_ready0", 32'(req_ready), 32'b01);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("alt%0d_id", i), 32'(rsp_id), 32'(i % 2));
            chk($sformatf("alt%0d_res", i), rsp_result,
                (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d_zero", i), 32'(rsp_zero),
                (i % 2 == 1) ? 32'd0 : 32'd1);
        end

        // Backpressure: held response is id1 SLT result.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_id", i), 32'(rsp_id), 32'd1);
            chk($sformatf("bp%0d_res", i), rsp_result, 32'd1);
            chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1;
        chk("bp_next_valid", 32'(rsp_valid), 32'd1);
        chk("bp_next_id", 32'(rsp_id), 32'd0);
        chk("bp_next_zero", 32'(rsp_zero), 32'd1);

        // Async reset while FULL with pointer at 1.
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_zero", 32'(rsp_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("arst_ready0", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1;
        chk("arst_first_id", 32'(rsp_id), 32'd0);

`ifdef ALU_ARB_LOCK_EN
        // req1 holds the ALU for three locked ops, then unlocks.
        req_valid = 2'b10;
        lock = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            req_valid = 2'b11;
            if (i == 2) lock = 2'b00;
            chk($sformatf("lock%0d_id", i), 32'(rsp_id),
                (i < 4) ? 32'd1 : 32'd0);
        end
        lock = 2'b00;
`endif

        req_valid = '0;
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
